// File: rtl/sirv_tl_fragmenter_a.sv
// -----------------------------------------------------------------------------
// sirv_tl_fragmenter_a
//
// Purpose:
//   Splits TileLink A-channel messages into single-byte fragments with no added
//   latency.
//   - A Get is presented once by the upstream repeater. This block raises
//     repeat_en so the repeater re-presents the same beat until all 2^size
//     fragments have been issued.
//   - A PutFull or PutPartial arrives as 2^size one-byte beats, and each beat
//     becomes exactly one fragment.
//   The low address bits of each fragment are ORed with the running byte offset.
//   Messages larger than 2^MAX_SIZE bytes are clamped to 2^MAX_SIZE fragments and
//   set a sticky error flag.
//
// Parameters:
//   MAX_SIZE   log2 of the largest accepted message size in bytes (0..3; the
//              offset counter is 3 bits wide).
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    upstream A-channel handshake (pass-through)
//   in_bits_*            upstream A-channel fields
//   repeat_en            ask the repeater to hold and replay the current beat
//   out_valid/out_ready  downstream handshake (pass-through)
//   out_bits_*           single-byte fragment fields (size always 0)
//   out_last             current fragment is the final one of its message
//   err_oversize         sticky: a message with size > MAX_SIZE was accepted
// -----------------------------------------------------------------------------
module sirv_tl_fragmenter_a #(
    parameter int MAX_SIZE = 3
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_bits_opcode,
    input  logic [2:0]  in_bits_param,
    input  logic [2:0]  in_bits_size,
    input  logic [1:0]  in_bits_source,
    input  logic [29:0] in_bits_address,
    input  logic        in_bits_mask,
    input  logic [7:0]  in_bits_data,

    output logic        repeat_en,

    input  logic        out_ready,
    output logic        out_valid,
    output logic [2:0]  out_bits_opcode,
    output logic [2:0]  out_bits_param,
    output logic [2:0]  out_bits_size,
    output logic [1:0]  out_bits_source,
    output logic [29:0] out_bits_address,
    output logic        out_bits_mask,
    output logic [7:0]  out_bits_data,
    output logic        out_last,

    output logic        err_oversize
);

    localparam logic [2:0] MAX_SZ    = 3'(MAX_SIZE);
    localparam logic [2:0] OPCODE_GET = 3'd4;

    // Byte offset within the current message, latched message size and
    // sticky oversize flag.
    logic [2:0] off_q,  off_d;
    logic [2:0] size_q, size_d;
    logic       err_q,  err_d;

    logic       fire;
    logic       is_get;
    logic       oversize;
    logic [2:0] eff_size;
    logic [2:0] msg_size;
    logic [3:0] last_off;
    logic       last;

    // -------------------------------------------------------------------------
    // Message bookkeeping
    // -------------------------------------------------------------------------
    always_comb begin
        fire     = in_valid & out_ready;
        is_get   = (in_bits_opcode == OPCODE_GET);
        oversize = (in_bits_size > MAX_SZ);
        eff_size = oversize ? MAX_SZ : in_bits_size;

        // On the first fragment, size_q still holds the previous message, so
        // use the live size field instead.
        msg_size = (off_q == 3'd0) ? eff_size : size_q;

        // The widened compare keeps 2^3 - 1 from overflowing.
        last_off = (4'd1 << msg_size) - 4'd1;
        last     = ({1'b0, off_q} == last_off);
    end

    always_comb begin
        off_d  = off_q;
        size_d = size_q;
        err_d  = err_q;
        if (fire) begin
            if (off_q == 3'd0) begin
                size_d = eff_size;
            end
            off_d = last ? 3'd0 : (off_q + 3'd1);
            if (oversize) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            off_q  <= 3'd0;
            size_q <= 3'd0;
            err_q  <= 1'b0;
        end else begin
            off_q  <= off_d;
            size_q <= size_d;
            err_q  <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Zero-latency datapath
    // -------------------------------------------------------------------------
    assign out_valid       = in_valid;
    assign in_ready        = out_ready;
    assign out_bits_opcode = in_bits_opcode;
    assign out_bits_param  = in_bits_param;
    assign out_bits_size   = 3'd0;
    assign out_bits_source = in_bits_source;
    assign out_bits_data   = in_bits_data;

    // A Get requests a full-width read, so every byte lane is enabled.
    assign out_bits_mask   = is_get ? 1'b1 : in_bits_mask;

    assign out_last        = last;
    assign repeat_en       = in_valid & is_get & ~last;
    assign err_oversize    = err_q;

    // The message is aligned to 2^size, so ORing the offset into the low bits
    // is the same as adding it.
    assign out_bits_address[29:3] = in_bits_address[29:3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_addr_lo
            assign out_bits_address[gi] = in_bits_address[gi] | off_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_sirv_tl_fragmenter_a.sv
// -----------------------------------------------------------------------------
// tb_sirv_tl_fragmenter_a
//
// Purpose:
//   Self-checking bench for sirv_tl_fragmenter_a.
//   - Whole messages are described by opcode, size, base address and first
//     data byte.
//   - The bench plays the upstream repeater: it re-presents a Get until its
//     last fragment fires, and presents one beat per fragment for Puts.
//   - At each step the bench predicts the expected fragment from the fragment
//     index k: address = base + k, last = (k == n - 1), and repeat_en only for
//     a valid Get that is not yet on its last fragment.
// -----------------------------------------------------------------------------
module tb_sirv_tl_fragmenter_a;

    localparam int MAX_SIZE = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_bits_opcode = '0;
    logic [2:0]  in_bits_param = '0;
    logic [2:0]  in_bits_size = '0;
    logic [1:0]  in_bits_source = '0;
    logic [29:0] in_bits_address = '0;
    logic        in_bits_mask = 1'b0;
    logic [7:0]  in_bits_data = '0;
    logic        repeat_en;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [2:0]  out_bits_opcode;
    logic [2:0]  out_bits_param;
    logic [2:0]  out_bits_size;
    logic [1:0]  out_bits_source;
    logic [29:0] out_bits_address;
    logic        out_bits_mask;
    logic [7:0]  out_bits_data;
    logic        out_last;
    logic        err_oversize;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic err_exp = 1'b0;

    sirv_tl_fragmenter_a #(.MAX_SIZE(MAX_SIZE)) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_bits_opcode   (in_bits_opcode),
        .in_bits_param    (in_bits_param),
        .in_bits_size     (in_bits_size),
        .in_bits_source   (in_bits_source),
        .in_bits_address  (in_bits_address),
        .in_bits_mask     (in_bits_mask),
        .in_bits_data     (in_bits_data),
        .repeat_en        (repeat_en),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_bits_opcode  (out_bits_opcode),
        .out_bits_param   (out_bits_param),
        .out_bits_size    (out_bits_size),
        .out_bits_source  (out_bits_source),
        .out_bits_address (out_bits_address),
        .out_bits_mask    (out_bits_mask),
        .out_bits_data    (out_bits_data),
        .out_last         (out_last),
        .err_oversize     (err_oversize)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Send one message.
    //   rmode:    0 = ready always high, 1 = ready toggles 1,0,..., 2 = random
    //   gap_pct:  chance of in_valid being low on a given cycle
    //   abort_at: stop after this many fires (0 = run the whole message)
    // Called at posedge + 1.
    task automatic send_msg(input logic [2:0] op, input logic [2:0] sz,
                            input logic [29:0] addr, input logic [7:0] d0,
                            input int rmode, input int gap_pct, input int abort_at);
        int         eff;
        int         n;
        int         k;
        int         cyc;
        logic       v;
        logic       r;
        logic       tog;
        logic [1:0] src;
        logic [2:0] prm;
        logic       msk;
        logic [7:0] dat;
        logic [29:0] exp_addr;
        logic        exp_rep;
        logic        exp_msk;

        eff = (int'(sz) > MAX_SIZE) ? MAX_SIZE : int'(sz);
        n   = 1 << eff;
        k   = 0;
        cyc = 0;
        tog = 1'b1;
        src = 2'($urandom);
        prm = 3'($urandom);

        while (k < n && !(abort_at > 0 && k == abort_at)) begin
            if (cyc > 400) begin
                check("timeout_frags", k, n);
                break;
            end

            v = ($urandom_range(99) >= gap_pct);
            case (rmode)
                0:       r = 1'b1;
                1:       begin r = tog; tog = ~tog; end
                default: r = 1'($urandom_range(1));
            endcase

            dat = d0 + 8'(k * 17);
            msk = 1'($urandom_range(1));

            in_valid        = v;
            out_ready       = r;
            in_bits_opcode  = op;
            in_bits_param   = prm;
            in_bits_size    = sz;
            in_bits_source  = src;
            in_bits_address = addr;
            in_bits_mask    = msk;
            in_bits_data    = dat;

            @(negedge clock);

            exp_addr = addr + 30'(k);
            exp_rep  = (op == 3'd4) && (k != n - 1);
            exp_msk  = (op == 3'd4) ? 1'b1 : msk;

            check("out_valid", 32'(out_valid), 32'(v));
            check("in_ready", 32'(in_ready), 32'(r));
            if (v) begin
                check("addr", 32'(out_bits_address), 32'(exp_addr));
                check("size", 32'(out_bits_size), 32'd0);
                check("opcode", 32'(out_bits_opcode), 32'(op));
                check("param", 32'(out_bits_param), 32'(prm));
                check("source", 32'(out_bits_source), 32'(src));
                check("data", 32'(out_bits_data), 32'(dat));
                check("mask", 32'(out_bits_mask), 32'(exp_msk));
                check("last", 32'(out_last), 32'(k == n - 1));
                check("repeat_en", 32'(repeat_en), 32'(exp_rep));
            end else begin
                check("repeat_idle", 32'(repeat_en), 32'd0);
            end
            check("err_oversize", 32'(err_oversize), 32'(err_exp));

            @(posedge clock);
            #1;
            if (v && r) begin
                if (int'(sz) > MAX_SIZE) begin
                    err_exp = 1'b1;
                end
                k++;
            end
            cyc++;
        end

        in_valid  = 1'b0;
        out_ready = 1'b0;
        $display("msg op=%0d size=%0d addr=0x%0h frags=%0d/%0d cycles=%0d",
                 op, sz, addr, k, n, cyc);
    endtask

    // Pulse reset and check the idle state while it is held.
    // Called at posedge + 1.
    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        err_exp  = 1'b0;
        #2;
        check("rst_err", 32'(err_oversize), 32'd0);
        @(negedge clock);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_repeat", 32'(repeat_en), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0]  op;
        logic [2:0]  sz;
        logic [29:0] a;
        int          sel;

        // Initial reset
        repeat (2) @(posedge clock);
        #1;
        do_reset();
        @(negedge clock);
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_repeat", 32'(repeat_en), 32'd0);
        check("idle_err", 32'(err_oversize), 32'd0);
        @(posedge clock);
        #1;

        // Directed cases
        send_msg(3'd4, 3'd2, 30'h100, 8'h00, 0, 0, 0);  // Get, 4 fragments
        send_msg(3'd0, 3'd1, 30'h20,  8'hAA, 0, 0, 0);  // PutFull, data 0xAA then 0xBB
        send_msg(3'd4, 3'd3, 30'h48,  8'h5C, 1, 0, 0);  // Get, toggling ready
        send_msg(3'd4, 3'd5, 30'h2A0, 8'h11, 0, 0, 0);  // oversize Get, clamped to 8
        send_msg(3'd1, 3'd0, 30'h7,   8'h33, 2, 30, 0); // error flag must stay set
        send_msg(3'd4, 3'd2, 30'h40,  8'h00, 0, 0, 2);  // abandoned after 2 fires
        do_reset();
        send_msg(3'd4, 3'd0, 30'h13,  8'h9E, 0, 0, 0);  // one fragment, last

        // Random messages
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(2);
            op  = (sel == 0) ? 3'd0 : (sel == 1) ? 3'd1 : 3'd4;
            sz  = 3'($urandom_range(5));
            a   = 30'($urandom) & ~((30'd1 << sz) - 30'd1);
            send_msg(op, sz, a, 8'($urandom), $urandom_range(2), 25, 0);
            if ($urandom_range(19) == 0) begin
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sirv_tl_fragmenter_a.md
SIRV_TL_FRAGMENTER_A -- requirements
Module: sirv_tl_fragmenter_a

Interface
REQ-001 SHALL have parameter MAX_SIZE, default 3, meaning log2 of the largest accepted message size in bytes; output beat width is 1 byte.
REQ-002 SHALL have port clock  in  1  rising-edge clock.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  in  1  A-channel request valid, from the upstream repeater.
REQ-005 SHALL have port in_ready  out  1  A-channel request accept, to the repeater.
REQ-006 SHALL have port in_bits_opcode  in  3  TileLink A opcode: 0 PutFull, 1 PutPartial, 4 Get.
REQ-007 SHALL have port in_bits_param  in  3  A param.
REQ-008 SHALL have port in_bits_size  in  3  log2 message size.
REQ-009 SHALL have port in_bits_source  in  2  source ID.
REQ-010 SHALL have port in_bits_address  in  30  byte address, aligned to 2^size.
REQ-011 SHALL have port in_bits_mask  in  1  byte mask.
REQ-012 SHALL have port in_bits_data  in  8  write data.
REQ-013 SHALL have port repeat_en  out  1  request the repeater to hold and re-present the current beat.
REQ-014 SHALL have port out_ready  in  1  downstream accept.
REQ-015 SHALL have port out_valid  out  1  fragment valid.
REQ-016 SHALL have ports out_bits_opcode (out, 3), out_bits_param (out, 3), out_bits_size (out, 3), out_bits_source (out, 2), out_bits_address (out, 30), out_bits_mask (out, 1), out_bits_data (out, 8), each carrying the single-byte fragment fields.
REQ-017 SHALL have port out_last  out  1  current fragment is the final one of its message.
REQ-018 SHALL have port err_oversize  out  1  sticky flag, set when a message with size > MAX_SIZE is accepted.

Function
REQ-019 SHALL pass the handshake through combinationally: out_valid = in_valid, in_ready = out_ready, fire = out_valid & out_ready.
REQ-020 SHALL keep an offset register off[2:0]: 0 at message start, +1 on each non-last fire, cleared to 0 on a last fire.
REQ-021 SHALL latch size_q <= effective size on a fire with off==0; effective size = in_bits_size clamped to MAX_SIZE.
REQ-022 SHALL use msg_size = (off==0) ? clamped in_bits_size : size_q; last = (off == 2^msg_size - 1).
REQ-023 SHALL drive out_bits_address = {in_bits_address[29:3], in_bits_address[2:0] | off}.
REQ-024 SHALL drive out_bits_size = 0 always; opcode, param, source and data SHALL pass through unchanged.
REQ-025 SHALL drive out_bits_mask = 1 for Get, otherwise in_bits_mask.
REQ-026 SHALL assert repeat_en = in_valid & (opcode==4) & ~last, so a Get beat is replayed for 2^size fragments from a single upstream beat.
REQ-027 SHALL treat all non-Get opcodes as one fragment per upstream beat with repeat_en = 0; upstream delivers 2^size beats.
REQ-028 SHALL drive out_last = last.
REQ-029 SHALL hold off and size_q when no fire occurs; out_valid = 0 mid-message SHALL stall without loss.
REQ-030 SHALL set err_oversize on a fire with in_bits_size > MAX_SIZE, clamp as in REQ-021, and clear it only by reset.
REQ-031 SHALL give size-0 messages exactly one fragment with out_last = 1 and repeat_en = 0.
REQ-032 SHALL have zero-cycle latency in->out; no output register.

Reset
REQ-033 SHALL on reset set off = 0, size_q = 0 and err_oversize = 0.
REQ-034 SHALL after reset with in_valid = 0 drive out_valid = 0 and repeat_en = 0.
REQ-035 SHALL on reset assertion mid-message abandon the message; the next fire after reset SHALL be treated as off = 0.

Verification
REQ-036 Get, size 2, addr 0x100, out_ready = 1 -> 4 fires at addr 0x100..0x103, size 0, mask 1; repeat_en = 1,1,1,0; out_last only on the 4th.
REQ-037 PutFull, size 1, addr 0x20, data 0xAA then 0xBB -> fragments 0x20/0xAA and 0x21/0xBB; repeat_en = 0 throughout; out_last on the 2nd.
REQ-038 Get, size 3, out_ready toggles 1,0,1,0... -> off advances only on fires; 8 fragments at addresses base+0..7 in order.
REQ-039 Get, size 5 -> err_oversize = 1 after the first fire; 8 fragments; flag stays set until reset.
REQ-040 Get, size 2, reset asserted after 2 fires -> off = 0, err_oversize = 0; next Get, size 0 -> 1 fragment, out_last = 1.
